dbus_sram_responder: RTL and testbench
======================================

DBUS_SRAM_RESPONDER -- requirements
Module: dbus_sram_responder

Interface
REQ-001 Parameter DEPTH, default 512: number of 64-bit RAM words; power of two, minimum 2.
REQ-002 Parameter LATENCY, default 2: cycles from request acceptance to data_ok; legal range 1..15.
REQ-003 Parameter BASE, default 64'h8000_0000: byte address of word 0; aligned to DEPTH*8.
REQ-004 Port clk, input, 1: single clock, all state on posedge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port dreq, input, dbus_req_t: request from the initiator (valid, addr, size, strobe, data).
REQ-007 Port dresp, output, dbus_resp_t: response to the initiator (addr_ok, data_ok, data).
REQ-008 Port oob, output, 1: one-cycle pulse coincident with data_ok when the completed request fell outside the RAM window.

Function
REQ-009 The block SHALL implement the FSM states IDLE, BUSY and RESP.
REQ-010 IDLE: when dreq.valid=1, the block SHALL assert dresp.addr_ok combinationally in that cycle, latch addr, strobe and data, and move to BUSY with counter=LATENCY-1.
REQ-011 IDLE with dreq.valid=0: no state change, addr_ok=0.
REQ-012 BUSY: the counter SHALL decrement each cycle; at counter=0 the block SHALL move to RESP.
REQ-013 When LATENCY=1, the block SHALL go from IDLE directly to RESP, so data_ok is asserted the cycle after acceptance.
REQ-014 RESP: dresp.data_ok=1 for exactly one cycle, then unconditionally IDLE; a dreq.valid in the RESP cycle SHALL NOT be accepted.
REQ-015 addr_ok SHALL be 0 in BUSY and RESP; data_ok SHALL be 0 outside RESP.
REQ-016 Changes on dreq after acceptance SHALL be ignored; only latched values are used.
REQ-017 Index = (addr - BASE) >> 3, truncated to log2(DEPTH) bits; addr[2:0] ignored (initiator pre-aligns data/strobe).
REQ-018 In range means BASE <= addr < BASE + DEPTH*8, compared at full 64-bit width.
REQ-019 Read (strobe=0) in range: dresp.data SHALL be the full 64-bit word at index, sampled in the RESP cycle, valid only while data_ok=1, and 0 otherwise.
REQ-020 Write (strobe!=0) in range: at the RESP-cycle clock edge, byte i SHALL be written from data[8i+7:8i] for each strobe[i]=1; other bytes unchanged; dresp.data=0.
REQ-021 A read issued after a write completes SHALL return the written value (no stale bypass window).
REQ-022 Out of range: reads SHALL return 0, writes SHALL be dropped, and oob=1 during the RESP cycle.
REQ-023 dreq.size SHALL NOT affect behaviour; strobe alone defines write bytes.
REQ-024 Throughput: at most one request per LATENCY+1 cycles; back-to-back requests are accepted in the IDLE cycle following RESP.

Reset
REQ-025 On reset, the block SHALL force state=IDLE, counter=0, latched request=0, and addr_ok, data_ok, data and oob to 0 on the next edge.
REQ-026 Reset SHALL take priority over all transitions, including the RESP-cycle write.
REQ-027 Reset during BUSY or RESP SHALL abort the request, commit no write, and emit no data_ok.
REQ-028 RAM contents SHALL NOT be cleared by reset; simulation initial contents are zero.
REQ-029 While reset=1, addr_ok SHALL be 0 regardless of dreq.valid.

Verification
REQ-030 Write then read, LATENCY=2: write addr=BASE+8, strobe=8'hFF, data=64'h1122334455667788 -> addr_ok in cycle 0, data_ok in cycle 2; then read BASE+8 -> data_ok in cycle 2 of that request with data=64'h1122334455667788.
REQ-031 Partial strobe: word = 64'hFFFF_FFFF_FFFF_FFFF, write strobe=8'h0C, data=64'h0000_0000_ABCD_0000 -> readback 64'hFFFF_FFFF_ABCD_FFFF.
REQ-032 Hold stability: initiator holds valid and changes data after acceptance -> originally latched data written, exactly one data_ok, no second acceptance in the RESP cycle.
REQ-033 Out of range: read BASE-8 and write BASE+DEPTH*8 -> data=0 with oob=1 on each data_ok; word 0 and word DEPTH-1 unchanged.
REQ-034 Reset mid-write: accept write BASE, data=64'hDEAD, then assert reset in cycle 1 -> no data_ok; later read of BASE returns its prior value.
REQ-035 LATENCY=1 back-to-back: valid held high across two requests -> acceptances in cycles 0 and 2, data_ok in cycles 1 and 3.

Source files
------------

// File: rtl/dbus_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dbus_sram_responder
//  Description : Single-port 64-bit SRAM responder on a valid/addr_ok/data_ok
//                data bus. One outstanding request, fixed response latency,
//                byte-strobed writes, and out-of-window detection.
//  Revision    : 1.0 - initial release
// ============================================================================

package dbus_pkg;
    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;
endpackage

module dbus_sram_responder
    import dbus_pkg::*;
#(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 2,
    parameter logic [63:0] BASE    = 64'h8000_0000
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp,
    output logic       oob
);

    localparam int unsigned AW          = $clog2(DEPTH);
    localparam logic [63:0] c_WIN_BYTES = 64'(DEPTH) * 64'd8;
    localparam logic [3:0]  c_CNT_INIT  = 4'(LATENCY - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic [63:0] r_addr;
    logic [7:0]  r_strobe;
    logic [63:0] r_data;
    logic [63:0] r_mem [DEPTH];

    logic          w_accept;
    logic          w_resp;
    logic          w_in_range;
    logic          w_is_write;
    logic [63:0]   w_off;
    logic [AW-1:0] w_idx;
    logic          w_unused;

    // Request acceptance and response qualification; reset masks both so an
    // aborted request never shows a handshake.
    assign w_accept   = (r_state == c_IDLE) && dreq.valid && !reset;
    assign w_resp     = (r_state == c_RESP) && !reset;

    // Window check on the latched address. Testing the offset rather than
    // BASE+size avoids overflow when the window sits at the top of the map.
    assign w_off      = r_addr - BASE;
    assign w_in_range = (r_addr >= BASE) && (w_off < c_WIN_BYTES);
    assign w_idx      = w_off[AW+2:3];
    assign w_is_write = |r_strobe;

    assign dresp.addr_ok = w_accept;
    assign dresp.data_ok = w_resp;
    assign dresp.data    = (w_resp && w_in_range && !w_is_write) ? r_mem[w_idx] : 64'd0;
    assign oob           = w_resp && !w_in_range;

    // Transfer size carries no meaning here: the strobe alone selects bytes.
    assign w_unused = ^{dreq.size, w_off};

    // Request FSM: latch on acceptance, count out the latency, respond once.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= 64'd0;
            r_strobe <= 8'd0;
            r_data   <= 64'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (dreq.valid) begin
                        r_addr   <= dreq.addr;
                        r_strobe <= dreq.strobe;
                        r_data   <= dreq.data;
                        if (LATENCY <= 1) begin
                            r_state <= c_RESP;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_state <= c_BUSY;
                            r_cnt   <= c_CNT_INIT;
                        end
                    end
                end
                c_BUSY: begin
                    // Counter value 1 is the last BUSY cycle: data_ok then
                    // lands exactly LATENCY cycles after acceptance.
                    if (r_cnt <= 4'd1) begin
                        r_state <= c_RESP;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                    end
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Byte-strobed write committed at the end of the response cycle; never
    // cleared by reset, and suppressed when reset lands in that cycle.
    always_ff @(posedge clk) begin
        if (!reset && (r_state == c_RESP) && w_in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (r_strobe[i]) begin
                    r_mem[w_idx][8*i +: 8] <= r_data[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dbus_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dbus_sram_responder
//  Description : Self-checking bench for dbus_sram_responder: directed vector
//                table, hand-written reset / hold / back-to-back sequences,
//                and randomized traffic against a behavioural memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dbus_sram_responder;
    import dbus_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int          LAT   = 2;
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [63:0] WIN   = 64'(DEPTH) * 64'd8;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    dbus_req_t  req_a, req_b;
    dbus_resp_t resp_a, resp_b;
    logic       oob_a, oob_b;

    always #5 clk = ~clk;

    dbus_sram_responder #(.DEPTH(DEPTH), .LATENCY(LAT), .BASE(BASE)) u_dut_a (
        .clk(clk), .reset(rst_a), .dreq(req_a), .dresp(resp_a), .oob(oob_a)
    );

    dbus_sram_responder #(.DEPTH(DEPTH), .LATENCY(1), .BASE(BASE)) u_dut_b (
        .clk(clk), .reset(rst_b), .dreq(req_b), .dresp(resp_b), .oob(oob_b)
    );

    int checks   = 0;
    int failures = 0;
    logic [63:0] model_mem [DEPTH];

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  strb;
        logic [63:0] data;
        logic [63:0] exp_d;
        logic        exp_o;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit in_win(input logic [63:0] a);
        return (a >= BASE) && ((a - BASE) < WIN);
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'((a - BASE) / 64'd8);
    endfunction

    // One complete transaction on instance A, entered just after a negedge.
    // With hold=1 the initiator keeps valid high and scrambles the request
    // after acceptance; the latched values must still be the ones used.
    task automatic run_txn(input logic [63:0] addr, input logic [7:0] strb,
                           input logic [63:0] wdata, input bit hold,
                           output logic [63:0] got_d, output logic got_o);
        logic [63:0] exp_d;
        logic        exp_o;
        exp_o = !in_win(addr);
        exp_d = (!exp_o && strb == 8'd0) ? model_mem[widx(addr)] : 64'd0;
        got_d = 64'd0;
        got_o = 1'b0;
        req_a.valid  = 1'b1;
        req_a.addr   = addr;
        req_a.strobe = strb;
        req_a.data   = wdata;
        req_a.size   = 3'($urandom_range(0, 3));
        #1 chk("accept", 64'(resp_a.addr_ok), 64'd1);
        for (int c = 1; c <= LAT; c++) begin
            @(posedge clk); @(negedge clk);
            if (hold) begin
                req_a.data   = ~wdata;
                req_a.strobe = 8'hFF;
                req_a.addr   = BASE;
            end else begin
                req_a.valid = 1'b0;
            end
            #1;
            chk("no_reaccept", 64'(resp_a.addr_ok), 64'd0);
            chk("data_ok_timing", 64'(resp_a.data_ok), 64'(c == LAT));
            if (c == LAT) begin
                chk("rdata", resp_a.data, exp_d);
                chk("oob", 64'(oob_a), 64'(exp_o));
                got_d = resp_a.data;
                got_o = oob_a;
            end
        end
        @(posedge clk); @(negedge clk);
        req_a.valid = 1'b0;
        #1 chk("data_ok_single", 64'(resp_a.data_ok), 64'd0);
        if (!exp_o) begin
            for (int i = 0; i < 8; i++) begin
                if (strb[i]) model_mem[widx(addr)][8*i +: 8] = wdata[8*i +: 8];
            end
        end
    endtask

    initial begin
        logic [63:0] gd;
        logic        go;
        logic [63:0] ra;

        tbl[0]  = '{BASE + 64'd8,   8'hFF, 64'h1122334455667788, 64'd0, 1'b0};
        tbl[1]  = '{BASE + 64'd8,   8'h00, 64'd0, 64'h1122334455667788, 1'b0};
        tbl[2]  = '{BASE + 64'd16,  8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0};
        tbl[3]  = '{BASE + 64'd16,  8'h0C, 64'h0000_0000_ABCD_0000, 64'd0, 1'b0};
        tbl[4]  = '{BASE + 64'd16,  8'h00, 64'd0, 64'hFFFF_FFFF_ABCD_FFFF, 1'b0};
        tbl[5]  = '{BASE,           8'hFF, 64'h0123456789ABCDEF, 64'd0, 1'b0};
        tbl[6]  = '{BASE + WIN - 8, 8'hFF, 64'hCAFE_F00D_BEEF_0001, 64'd0, 1'b0};
        tbl[7]  = '{BASE - 64'd8,   8'h00, 64'd0, 64'd0, 1'b1};
        tbl[8]  = '{BASE + WIN,     8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1};
        tbl[9]  = '{BASE + WIN + 8, 8'hFF, 64'h9999_9999_9999_9999, 64'd0, 1'b1};
        tbl[10] = '{BASE,           8'h00, 64'd0, 64'h0123456789ABCDEF, 1'b0};
        tbl[11] = '{BASE + WIN - 8, 8'h00, 64'd0, 64'hCAFE_F00D_BEEF_0001, 1'b0};
        tbl[12] = '{BASE + 64'd19,  8'h00, 64'd0, 64'hFFFF_FFFF_ABCD_FFFF, 1'b0};
        tbl[13] = '{BASE + 64'd8,   8'h00, 64'd0, 64'h1122334455667788, 1'b0};

        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = 64'd0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        req_a = '0;
        req_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_a.valid = 1'b1;
        #1 chk("addr_ok_during_reset", 64'(resp_a.addr_ok), 64'd0);
        chk("reset_data_ok", 64'(resp_a.data_ok), 64'd0);
        chk("reset_data", resp_a.data, 64'd0);
        chk("reset_oob", 64'(oob_a), 64'd0);
        @(posedge clk); @(negedge clk);
        req_a.valid = 1'b0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk); @(negedge clk);

        // Give the RAM a known image independent of simulator start-up values.
        for (int i = 0; i < int'(DEPTH); i++) run_txn(BASE + 64'(i) * 64'd8, 8'hFF, 64'd0, 1'b0, gd, go);

        // Directed vector table.
        for (int i = 0; i < 14; i++) begin
            run_txn(tbl[i].addr, tbl[i].strb, tbl[i].data, 1'b0, gd, go);
            chk($sformatf("vec%0d_data", i), gd, tbl[i].exp_d);
            chk($sformatf("vec%0d_oob", i), 64'(go), 64'(tbl[i].exp_o));
        end

        // Initiator holds valid and changes the request after acceptance.
        run_txn(BASE + 64'd40, 8'hFF, 64'h5555AAAA12345678, 1'b1, gd, go);
        run_txn(BASE + 64'd40, 8'h00, 64'd0, 1'b0, gd, go);
        chk("hold_latched_data", gd, 64'h5555AAAA12345678);

        // Reset in the BUSY cycle of a write aborts it.
        req_a.valid = 1'b1; req_a.addr = BASE; req_a.strobe = 8'hFF; req_a.data = 64'hDEAD;
        #1 chk("rst_busy_accept", 64'(resp_a.addr_ok), 64'd1);
        @(posedge clk); @(negedge clk);
        rst_a = 1'b1;
        #1 chk("rst_busy_addr_ok", 64'(resp_a.addr_ok), 64'd0);
        @(posedge clk); @(negedge clk);
        rst_a = 1'b0;
        req_a.valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 chk("rst_busy_no_data_ok", 64'(resp_a.data_ok), 64'd0);
            @(posedge clk); @(negedge clk);
        end
        run_txn(BASE, 8'h00, 64'd0, 1'b0, gd, go);
        chk("rst_busy_word0", gd, 64'h0123456789ABCDEF);

        // Reset in the RESP cycle of a write: no data_ok and no commit.
        req_a.valid = 1'b1; req_a.addr = BASE; req_a.strobe = 8'hFF; req_a.data = 64'hDEAD;
        #1 chk("rst_resp_accept", 64'(resp_a.addr_ok), 64'd1);
        @(posedge clk); @(negedge clk);
        req_a.valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_a = 1'b1;
        #1 chk("rst_resp_data_ok", 64'(resp_a.data_ok), 64'd0);
        chk("rst_resp_oob", 64'(oob_a), 64'd0);
        @(posedge clk); @(negedge clk);
        rst_a = 1'b0;
        #1 chk("rst_resp_after", 64'(resp_a.data_ok), 64'd0);
        @(posedge clk); @(negedge clk);
        run_txn(BASE, 8'h00, 64'd0, 1'b0, gd, go);
        chk("rst_resp_word0", gd, 64'h0123456789ABCDEF);

        // Randomized traffic across and just beyond both window edges.
        for (int n = 0; n < 80; n++) begin
            ra = BASE - 64'd16 + 64'($urandom_range(0, DEPTH + 3)) * 64'd8 + 64'($urandom_range(0, 7));
            run_txn(ra, ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                    {$urandom, $urandom}, bit'($urandom_range(0, 1)), gd, go);
        end

        // LATENCY=1 instance with valid held across two requests.
        req_b.valid = 1'b1; req_b.addr = BASE + 64'd8; req_b.strobe = 8'hFF;
        req_b.data = 64'hA5A5_0000_1234_5678; req_b.size = 3'd3;
        #1 chk("l1_acc0", 64'(resp_b.addr_ok), 64'd1);
        chk("l1_acc0_no_data_ok", 64'(resp_b.data_ok), 64'd0);
        @(posedge clk); @(negedge clk);
        req_b.strobe = 8'h00;
        #1 chk("l1_resp0", 64'(resp_b.data_ok), 64'd1);
        chk("l1_resp0_no_accept", 64'(resp_b.addr_ok), 64'd0);
        chk("l1_resp0_wdata", resp_b.data, 64'd0);
        @(posedge clk); @(negedge clk);
        #1 chk("l1_acc1", 64'(resp_b.addr_ok), 64'd1);
        chk("l1_acc1_no_data_ok", 64'(resp_b.data_ok), 64'd0);
        @(posedge clk); @(negedge clk);
        req_b.valid = 1'b0;
        #1 chk("l1_resp1", 64'(resp_b.data_ok), 64'd1);
        chk("l1_resp1_rdata", resp_b.data, 64'hA5A5_0000_1234_5678);
        chk("l1_resp1_oob", 64'(oob_b), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
